// File: rtl/io_intr_if.sv
// -----------------------------------------------------------------------------
// io_intr_if -- bus bundle for io_intr_unit
//
// Groups the device-side input offer, the device-side output offer and the
// interrupt handshake with the fetch stage.
//
//   in_valid / in_data / in_ready     device input word offer and accept
//   out_valid / out_data / out_ready  device output word offer and accept
//   int_req / int_ack                 interrupt request and acknowledge
//
// Modports:
//   master : the I/O unit side (drives in_ready, out_*, int_req)
//   slave  : the device / fetch side (drives in_valid, in_data, out_ready,
//            int_ack)
// -----------------------------------------------------------------------------
interface io_intr_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic              int_req;
    logic              int_ack;

    modport master (
        input  in_valid, in_data, out_ready, int_ack,
        output in_ready, out_valid, out_data, int_req
    );

    modport slave (
        output in_valid, in_data, out_ready, int_ack,
        input  in_ready, out_valid, out_data, int_req
    );
endinterface

// File: rtl/io_intr_unit.sv
// -----------------------------------------------------------------------------
// io_intr_unit -- I/O flag registers, device word buffers and interrupt control
//
// Holds the input flag FI with its latched word inpr, the output flag FO with
// its output buffer, and the interrupt enable IEN with a small request FSM.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   rFI, sFO, rFO         flag strobes from the decoder (clear FI, set/clear FO)
//   ION, IOF              interrupt enable set / clear strobes
//   io_in, io_out         IN / OUT instruction strobes
//   acc_data              datapath word sent on OUT
//   inpr                  latched input word, continuously visible
//   FI, FO, IEN           current flag register values
//   bus (master modport)  device input/output handshakes and int_req/int_ack
//
// Build option:
//   IO_INTR_UNIT_INTR_EN  when defined, IEN is writable and the RUN/REQ/SVC
//                         interrupt FSM drives int_req; otherwise int_req is
//                         tied low, IEN is constant 1 and ION/IOF/int_ack are
//                         ignored.
// -----------------------------------------------------------------------------
module io_intr_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rFI,
    input  logic              sFO,
    input  logic              rFO,
    input  logic              ION,
    input  logic              IOF,
    input  logic              io_in,
    input  logic              io_out,
    input  logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] inpr,
    output logic              FI,
    output logic              FO,
    output logic              IEN,
    io_intr_if.master         bus
);

    logic              in_fire;
    logic              out_fire;
    logic              out_load;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;

    // The input buffer is a single word: it is full exactly when FI is set.
    assign bus.in_ready  = ~FI;
    assign in_fire       = bus.in_valid & ~FI;
    assign out_fire      = out_valid_r & bus.out_ready;
    // An OUT while a word is still pending is dropped so out_data stays stable.
    assign out_load      = io_out & ~out_valid_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FI   <= 1'b0;
            inpr <= '0;
        end else if (in_fire) begin
            FI   <= 1'b1;
            inpr <= bus.in_data;
        end else if (rFI) begin
            FI   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (out_fire) begin
            out_valid_r <= 1'b0;
        end else if (out_load) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_data;
        end
    end

    // A completed device handshake outranks the decoder strobes, and rFO
    // outranks sFO when both arrive together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FO <= 1'b0;
        end else if (out_fire) begin
            FO <= 1'b1;
        end else if (out_load || rFO) begin
            FO <= 1'b0;
        end else if (sFO) begin
            FO <= 1'b1;
        end
    end

`ifdef IO_INTR_UNIT_INTR_EN
    typedef enum logic [1:0] {
        RUN = 2'd0,
        REQ = 2'd1,
        SVC = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ien_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            IEN   <= 1'b1;
        end else begin
            state <= state_nxt;
            IEN   <= ien_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ien_nxt   = IEN;

        if (IOF) begin
            ien_nxt = 1'b0;
        end else if (ION) begin
            ien_nxt = 1'b1;
        end

        case (state)
            RUN: begin
                if (IEN && (FI || FO)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Losing IEN withdraws the request; IOF beats a same-cycle ack.
                if (IOF || !IEN) begin
                    state_nxt = RUN;
                end else if (bus.int_ack) begin
                    state_nxt = SVC;
                    ien_nxt   = 1'b0;
                end
            end
            SVC: begin
                if (ION && !IOF) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign bus.int_req = (state == REQ);

    logic unused_inputs;
    assign unused_inputs = &{1'b0, io_in};
`else
    assign IEN         = 1'b1;
    assign bus.int_req = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, io_in, ION, IOF, bus.int_ack};
`endif

endmodule

// File: tb/tb_io_intr_unit.sv
// -----------------------------------------------------------------------------
// tb_io_intr_unit -- self-checking bench for io_intr_unit
//
// Input and output words are pushed to scoreboard queues when driven and
// popped by a monitor when the unit latches an input word (FI rises) or
// completes an output handshake. Flag, enable and FSM behaviour is checked
// directly. Interrupt expectations follow IO_INTR_UNIT_INTR_EN.
// -----------------------------------------------------------------------------
module tb_io_intr_unit;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              rFI, sFO, rFO, ION, IOF, io_in, io_out;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] inpr;
    logic              FI, FO, IEN;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] sb_in[$];
    logic [DATA_W-1:0] sb_out[$];

    io_intr_if #(.DATA_W(DATA_W)) bus ();

    io_intr_unit #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rFI      (rFI),
        .sFO      (sFO),
        .rFO      (rFO),
        .ION      (ION),
        .IOF      (IOF),
        .io_in    (io_in),
        .io_out   (io_out),
        .acc_data (acc_data),
        .inpr     (inpr),
        .FI       (FI),
        .FO       (FO),
        .IEN      (IEN),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on an input latch and on an output handshake.
    initial begin
        logic fi_q;
        logic [DATA_W-1:0] exp_w;
        fi_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_out.delete();
                fi_q = 1'b0;
            end else begin
                if (FI && !fi_q) begin
                    if (sb_in.size() == 0) begin
                        check("sb_in_underflow", 1, 0);
                    end else begin
                        exp_w = sb_in.pop_front();
                        check("sb_inpr", inpr, exp_w);
                    end
                end
                fi_q = FI;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_out.size() == 0) begin
                        check("sb_out_underflow", 1, 0);
                    end else begin
                        exp_w = sb_out.pop_front();
                        check("sb_out_data", bus.out_data, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        {rFI, sFO, rFO, ION, IOF, io_in, io_out} = '0;
        acc_data     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        bus.int_ack  = 1'b0;

        // Reset state
        #2;
        check("rst_FI", FI, 0);
        check("rst_FO", FO, 0);
        check("rst_IEN", IEN, 1);
        check("rst_inpr", inpr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_int_req", bus.int_req, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Drop IEN (only effective with the interrupt build) to keep I/O tests quiet
        IOF = 1'b1; tick(); IOF = 1'b0;
`ifdef IO_INTR_UNIT_INTR_EN
        check("iof_IEN", IEN, 0);
`else
        check("iof_IEN_ignored", IEN, 1);
`endif

        // Input: first word accepted, second held off until rFI
        bus.in_valid = 1'b1; bus.in_data = 16'h00A5; sb_in.push_back(16'h00A5);
        tick();
        check("in1_FI", FI, 1);
        check("in1_in_ready", bus.in_ready, 0);
        bus.in_data = 16'h1234; sb_in.push_back(16'h1234);
        io_in = 1'b1;
        tick();
        io_in = 1'b0;
        check("in2_hold_inpr", inpr, 16'h00A5);
        tick();
        check("in2_hold_ready", bus.in_ready, 0);
        rFI = 1'b1; tick(); rFI = 1'b0;
        check("rfi_FI", FI, 0);
        check("rfi_in_ready", bus.in_ready, 1);
        check("rfi_inpr", inpr, 16'h00A5);
        tick();
        bus.in_valid = 1'b0;
        check("in2_FI", FI, 1);
        check("in2_inpr", inpr, 16'h1234);
        rFI = 1'b1; tick(); rFI = 1'b0;

        // Output: out_ready low for 3 cycles while valid, then high
        sFO = 1'b1; tick(); sFO = 1'b0;
        acc_data = 16'hBEEF; io_out = 1'b1; sb_out.push_back(16'hBEEF);
        tick();
        io_out = 1'b0;
        check("out_v1", bus.out_valid, 1);
        check("out_FO0", FO, 0);
        tick();
        check("out_v2", bus.out_valid, 1);
        acc_data = 16'h1111; io_out = 1'b1;
        tick();
        io_out = 1'b0;
        check("out_v3", bus.out_valid, 1);
        check("out_stable", bus.out_data, 16'hBEEF);
        tick();
        check("out_v4", bus.out_valid, 1);
        check("out_FO_wait", FO, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_done_valid", bus.out_valid, 0);
        check("out_done_FO", FO, 1);

        // Handshake with coincident rFO: handshake wins
        acc_data = 16'h7777; io_out = 1'b1; sb_out.push_back(16'h7777);
        tick();
        io_out = 1'b0;
        check("out2_FO0", FO, 0);
        bus.out_ready = 1'b1; rFO = 1'b1;
        tick();
        bus.out_ready = 1'b0; rFO = 1'b0;
        check("hs_rfo_FO", FO, 1);
        sFO = 1'b1; rFO = 1'b1; tick(); sFO = 1'b0; rFO = 1'b0;
        check("sfo_rfo_FO", FO, 0);
        sFO = 1'b1; tick(); sFO = 1'b0;
        check("sfo_FO", FO, 1);
        rFO = 1'b1; tick(); rFO = 1'b0;
        check("rfo_FO", FO, 0);

`ifdef IO_INTR_UNIT_INTR_EN
        ION = 1'b1; tick(); ION = 1'b0;
        check("ion_IEN", IEN, 1);
        check("ion_int_req", bus.int_req, 0);
        bus.in_valid = 1'b1; bus.in_data = 16'h5A5A; sb_in.push_back(16'h5A5A);
        tick();
        bus.in_valid = 1'b0;
        check("irq_pre", bus.int_req, 0);
        tick();
        check("irq_req", bus.int_req, 1);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        check("svc_IEN", IEN, 0);
        check("svc_int_req", bus.int_req, 0);
        tick();
        check("svc_hold", bus.int_req, 0);
        ION = 1'b1; tick(); ION = 1'b0;
        check("svc_ion_IEN", IEN, 1);
        check("svc_ion_int_req", bus.int_req, 0);
        tick();
        check("rerun_req", bus.int_req, 1);
        IOF = 1'b1; bus.int_ack = 1'b1; tick(); IOF = 1'b0; bus.int_ack = 1'b0;
        check("iof_ack_IEN", IEN, 0);
        check("iof_ack_int_req", bus.int_req, 0);
        tick();
        check("iof_ack_run", bus.int_req, 0);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        check("ack_ignored_IEN", IEN, 0);
        check("ack_ignored_req", bus.int_req, 0);
        rFI = 1'b1; tick(); rFI = 1'b0;
        ION = 1'b1; IOF = 1'b1; tick(); ION = 1'b0; IOF = 1'b0;
        check("ion_iof_IEN", IEN, 0);
        check("ion_iof_int_req", bus.int_req, 0);
`else
        bus.in_valid = 1'b1; bus.in_data = 16'h5A5A; sb_in.push_back(16'h5A5A);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("noirq_req", bus.int_req, 0);
        bus.int_ack = 1'b1; IOF = 1'b1; tick(); bus.int_ack = 1'b0; IOF = 1'b0;
        check("noirq_iof_IEN", IEN, 1);
        check("noirq_ack_req", bus.int_req, 0);
        rFI = 1'b1; tick(); rFI = 1'b0;
        ION = 1'b1; IOF = 1'b1; tick(); ION = 1'b0; IOF = 1'b0;
        check("ion_iof_IEN", IEN, 1);
`endif

        // Reset mid-output
        bus.in_valid = 1'b1; bus.in_data = 16'h0F0F; sb_in.push_back(16'h0F0F);
        tick();
        bus.in_valid = 1'b0;
        acc_data = 16'hCAFE; io_out = 1'b1; sb_out.push_back(16'hCAFE);
        tick();
        io_out = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_FI", FI, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_FO", FO, 0);
        check("arst_FI", FI, 0);
        check("arst_IEN", IEN, 1);
        check("arst_in_ready", bus.in_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h3C3C; sb_in.push_back(16'h3C3C);
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_FI", FI, 1);
        check("post_rst_valid", bus.out_valid, 0);
        tick();
        check("sb_in_left", sb_in.size(), 0);
        check("sb_out_left", sb_out.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/io_intr_unit.md
IO_INTR_UNIT -- requirements
Module: io_intr_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the device and datapath data words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rFI, sFO, rFO, ION, IOF, input, 1 each, flag/interrupt strobes from the decoder, sampled per clk.
REQ-005 SHALL have ports io_in, io_out, input, 1 each, asserted for the IN and OUT instructions respectively.
REQ-006 SHALL have port acc_data, input, DATA_W, datapath word sent on OUT.
REQ-007 SHALL have port inpr, output, DATA_W, latched input word driven to the datapath.
REQ-008 SHALL have ports in_valid, input, 1, and in_data, input, DATA_W, device input offer.
REQ-009 SHALL have port in_ready, output, 1, meaning the unit accepts in_data.
REQ-010 SHALL have ports out_valid, output, 1, and out_data, output, DATA_W, device output offer.
REQ-011 SHALL have port out_ready, input, 1, device output accept.
REQ-012 SHALL have ports FI, FO, IEN, output, 1 each, current flag register values.
REQ-013 SHALL have port int_req, output, 1, and int_ack, input, 1, interrupt handshake with the fetch stage.

Function
REQ-014 in_ready SHALL equal ~FI; an input transfer completes in a cycle with in_valid & in_ready, loading inpr<=in_data and FI<=1 at that edge.
REQ-015 rFI SHALL clear FI at the next edge; a transfer cannot coincide because in_ready is low while FI=1.
REQ-016 io_in SHALL NOT alter any register; inpr is continuously visible.
REQ-017 io_out with out_valid=0 SHALL load out_data<=acc_data, set out_valid=1 and clear FO at the next edge.
REQ-018 io_out with out_valid=1 SHALL be ignored; out_data stays stable until out_valid & out_ready.
REQ-019 on out_valid & out_ready, out_valid SHALL clear and FO SHALL set at the next edge; a coincident rFO loses (FO=1).
REQ-020 sFO SHALL set FO and rFO clear FO; both asserted together: rFO wins.
REQ-021 ION SHALL set IEN and IOF clear IEN; both together: IOF wins.
REQ-022 the interrupt FSM SHALL have states RUN, REQ, SVC; int_req=1 only in REQ.
REQ-023 RUN->REQ at an edge with IEN & (FI | FO); otherwise stays RUN.
REQ-024 REQ->SVC on int_ack, clearing IEN at the same edge; REQ->RUN if IEN is cleared by IOF before int_ack, with IOF taking precedence over a coincident int_ack.
REQ-025 SVC->RUN at the edge where ION sets IEN; an ION in RUN or REQ only sets IEN.
REQ-026 int_ack outside REQ SHALL be ignored.

Reset
REQ-027 reset SHALL asynchronously force: FI=0, FO=0, IEN=1, inpr=0, out_data=0, out_valid=0, FSM=RUN; hence int_req=0 and in_ready=1.
REQ-028 reset mid-transfer SHALL abandon any pending output; the first in_valid after release is accepted normally.

Configuration
REQ-029 with macro IO_INTR_UNIT_INTR_EN defined, REQ-021..REQ-026 SHALL apply.
REQ-030 without IO_INTR_UNIT_INTR_EN, the FSM SHALL be absent, int_req SHALL be tied 0, IEN SHALL stay at its reset value 1, ION/IOF/int_ack SHALL be ignored; flag and I/O behaviour SHALL be unchanged.

Verification
REQ-031 reset, in_valid=1 in_data=0x00A5 -> next edge inpr=0x00A5, FI=1, in_ready=0; second word 0x1234 held off until rFI pulse, then accepted.
REQ-032 io_out with acc_data=0xBEEF, out_ready=0 for 3 cycles then 1 -> out_valid high 4 cycles, out_data=0xBEEF throughout, FO 0 then 1; io_out during the wait leaves out_data=0xBEEF.
REQ-033 IEN=1, FI set by input -> int_req next cycle; int_ack -> SVC, IEN=0, int_req=0; ION -> RUN, IEN=1, int_req again while FI=1.
REQ-034 in REQ assert IOF and int_ack together -> IEN=0, FSM=RUN, int_req=0.
REQ-035 out handshake completes together with rFO -> FO=1; sFO with rFO -> FO=0; ION with IOF -> IEN=0.
REQ-036 reset asserted mid-output (out_valid=1) -> out_valid, FO, FI drop immediately without a clock edge, IEN=1.
